// File: rtl/ifetch_queue_if.sv
// Fetch bundle: instruction memory request/response, execute redirect, decode handoff.
// master = fetch unit, slave = surrounding core / memory / testbench.
interface ifetch_queue_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_insn;
  logic        id_ready;
  logic        fetch_fault;

  modport master (
    output imem_req, imem_addr, id_valid, id_pc, id_insn, fetch_fault,
    input  imem_rvalid, imem_rdata, redirect_valid, redirect_pc, id_ready
  );

  modport slave (
    input  imem_req, imem_addr, id_valid, id_pc, id_insn, fetch_fault,
    output imem_rvalid, imem_rdata, redirect_valid, redirect_pc, id_ready
  );
endinterface

// File: rtl/ifetch_queue.sv
// Fetch PC generator + DEPTH-entry in-order instruction queue; data reaches decode 1 cycle after rvalid, fetch stalls while outstanding+occupancy == DEPTH.
// IFETCH_ALIGN_CHECK_EN: a misaligned redirect sets a sticky fetch_fault and halts fetch instead of truncating the target.
module ifetch_queue #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic           clk,
  input  logic           rst,
  ifetch_queue_if.master bus
);
  localparam int          PW    = $clog2(DEPTH);
  localparam int          CW    = $clog2(DEPTH + 1);
  localparam logic [CW:0] LIMIT = (CW+1)'(DEPTH);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] FLUSH = 2'd2;

  logic [1:0]    state, state_nxt;
  logic [31:0]   fetch_pc, rsp_pc, target_pc;
  logic [CW-1:0] outstanding, occupancy, drained;
  logic [PW-1:0] head, tail;
  logic [31:0]   q_pc   [DEPTH];
  logic [31:0]   q_insn [DEPTH];
  logic          redirect, fault, rsp, issue, wr, pop, has_head;

  assign redirect = bus.redirect_valid;

`ifdef IFETCH_ALIGN_CHECK_EN
  assign target_pc = bus.redirect_pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      fault <= 1'b0;
    else if (redirect)
      fault <= |bus.redirect_pc[1:0];
  end
`else
  // Low target bits are simply dropped in this build.
  logic unused_pc_lsb;
  assign unused_pc_lsb = ^bus.redirect_pc[1:0];
  assign target_pc     = {bus.redirect_pc[31:2], 2'b00};
  assign fault         = 1'b0;
`endif

  assign has_head = (occupancy != '0);
  assign rsp      = bus.imem_rvalid && (outstanding != '0);
  assign issue    = (state == RUN) && !redirect && !fault &&
                    (({1'b0, outstanding} + {1'b0, occupancy}) < LIMIT);
  assign wr       = rsp && (state == RUN) && !redirect && !fault;
  assign pop      = has_head && bus.id_ready && !redirect;
  // Requests still owed after this cycle's response; decides FLUSH entry and exit.
  assign drained  = outstanding - CW'(rsp);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = RUN;
      RUN:     if (redirect && drained != '0) state_nxt = FLUSH;
      FLUSH:   if (!redirect && drained == '0) state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
      outstanding <= '0;
      occupancy   <= '0;
      head        <= '0;
      tail        <= '0;
    end else begin
      state <= state_nxt;

      if (redirect)   fetch_pc <= target_pc;
      else if (issue) fetch_pc <= fetch_pc + 32'd4;

      // PC of the next response that will be kept; responses return in request order.
      if (redirect)   rsp_pc <= target_pc;
      else if (wr)    rsp_pc <= rsp_pc + 32'd4;

      case ({issue, rsp})
        2'b10:   outstanding <= outstanding + CW'(1);
        2'b01:   outstanding <= outstanding - CW'(1);
        default: outstanding <= outstanding;
      endcase

      if (redirect) begin
        occupancy <= '0;
        head      <= '0;
        tail      <= '0;
      end else begin
        if (wr)  tail <= tail + PW'(1);
        if (pop) head <= head + PW'(1);
        case ({wr, pop})
          2'b10:   occupancy <= occupancy + CW'(1);
          2'b01:   occupancy <= occupancy - CW'(1);
          default: occupancy <= occupancy;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr) begin
      q_pc[tail]   <= rsp_pc;
      q_insn[tail] <= bus.imem_rdata;
    end
  end

  assign bus.imem_req    = issue;
  assign bus.imem_addr   = fetch_pc;
  assign bus.id_valid    = has_head;
  assign bus.id_pc       = has_head ? q_pc[head]   : 32'd0;
  assign bus.id_insn     = has_head ? q_insn[head] : 32'd0;
  assign bus.fetch_fault = fault;
endmodule

// File: tb/tb_ifetch_queue.sv
// Bench for ifetch_queue: scripted 1-cycle-memory table, directed redirect corner cases,
// then randomized traffic against a request-tagged queue model.
module tb_ifetch_queue;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          M_IDLE   = 0;
  localparam int          M_RUN    = 1;
  localparam int          M_FLUSH  = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_bad = 0;

  ifetch_queue_if bus ();

  ifetch_queue #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [31:0] addr; int due; } mreq_t;
  typedef struct { logic [31:0] addr; bit live; } fl_t;
  typedef struct { logic [31:0] pc; logic [31:0] insn; } ent_t;
  typedef struct {
    bit rvalid; logic [31:0] raddr; bit rdy;
    bit req; logic [31:0] addr; bit vld; logic [31:0] pc;
  } vec_t;

  mreq_t       mem_q[$];
  int          last_due;
  int          lat_lo = 1;
  int          lat_hi = 1;
  fl_t         m_fl[$];
  ent_t        m_dq[$];
  int          m_mode;
  logic [31:0] m_fpc;
  bit          m_fault;
  bit          redir_in, rdy_in;
  logic [31:0] rpc_in;
  bit          s_req, s_vld, s_fault;
  logic [31:0] s_addr, s_pc;
  vec_t        tv[14];

  function automatic logic [31:0] insn_of(logic [31:0] a);
    return a ^ 32'h0050_0093;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.imem_rvalid = 1'b0; bus.imem_rdata = '0;
    bus.redirect_valid = 1'b0; bus.redirect_pc = '0; bus.id_ready = 1'b0;
    redir_in = 1'b0; rdy_in = 1'b0; rpc_in = '0;
    mem_q.delete(); last_due = 0;
    m_fl.delete(); m_dq.delete();
    m_mode = M_IDLE; m_fpc = RESET_PC; m_fault = 1'b0;
    @(negedge clk);
    check("rst_req",   32'(bus.imem_req),    32'd0);
    check("rst_addr",  bus.imem_addr,        RESET_PC);
    check("rst_valid", 32'(bus.id_valid),    32'd0);
    check("rst_pc",    bus.id_pc,            32'd0);
    check("rst_insn",  bus.id_insn,          32'd0);
    check("rst_fault", 32'(bus.fetch_fault), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // One cycle: drive from redir_in/rdy_in/rpc_in + memory, check against model, advance model.
  task automatic cycle();
    mreq_t m; fl_t r; fl_t f; ent_t e; bit got, e_vld, e_req; logic [31:0] eff; int due;
    bus.redirect_valid = redir_in; bus.redirect_pc = rpc_in; bus.id_ready = rdy_in;
    if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      m = mem_q.pop_front();
      bus.imem_rvalid = 1'b1; bus.imem_rdata = insn_of(m.addr);
    end else begin
      bus.imem_rvalid = 1'b0; bus.imem_rdata = $urandom;
    end
    @(negedge clk);
    e_vld = m_dq.size() > 0;
    e_req = (m_mode == M_RUN) && !redir_in && !m_fault && (m_fl.size() + m_dq.size() < DEPTH);
    s_req = bus.imem_req; s_addr = bus.imem_addr; s_vld = bus.id_valid;
    s_pc = bus.id_pc; s_fault = bus.fetch_fault;
    check("id_valid", 32'(bus.id_valid), 32'(e_vld));
    if (e_vld) begin
      check("id_pc",   bus.id_pc,   m_dq[0].pc);
      check("id_insn", bus.id_insn, m_dq[0].insn);
    end
    check("imem_req", 32'(bus.imem_req), 32'(e_req));
    if (e_req) check("imem_addr", bus.imem_addr, m_fpc);
    check("fetch_fault", 32'(bus.fetch_fault), 32'(m_fault));
    if (bus.imem_req) begin
      due = cyc + int'($urandom_range(lat_hi, lat_lo));
      if (due <= last_due) due = last_due + 1;
      m.addr = bus.imem_addr; m.due = due;
      mem_q.push_back(m);
      last_due = due;
    end
    got = 1'b0;
    if (bus.imem_rvalid && m_fl.size() > 0) begin
      r = m_fl.pop_front(); got = 1'b1;
    end
`ifdef IFETCH_ALIGN_CHECK_EN
    eff = rpc_in;
`else
    eff = {rpc_in[31:2], 2'b00};
`endif
    if (redir_in) begin
      m_dq.delete();
      foreach (m_fl[i]) m_fl[i].live = 1'b0;
      m_fpc = eff;
`ifdef IFETCH_ALIGN_CHECK_EN
      m_fault = (rpc_in[1:0] != 2'b00);
`endif
      if (m_mode != M_FLUSH) m_mode = (m_fl.size() > 0) ? M_FLUSH : M_RUN;
    end else begin
      if (e_vld && rdy_in) void'(m_dq.pop_front());
      if (got && r.live && m_mode == M_RUN && !m_fault) begin
        e.pc = r.addr; e.insn = insn_of(r.addr); m_dq.push_back(e);
      end
      if (e_req) begin
        f.addr = m_fpc; f.live = 1'b1; m_fl.push_back(f); m_fpc = m_fpc + 32'd4;
      end
      if (m_mode == M_IDLE) m_mode = M_RUN;
      else if (m_mode == M_FLUSH && m_fl.size() == 0) m_mode = M_RUN;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    int          k, nreq;
    bit          vseen;
    logic [31:0] first;
    logic [31:0] wa[3];

    // rvalid raddr rdy | req addr vld pc  (1-cycle memory, cycle 0 = first cycle after reset)
    tv[0]  = '{1'b0, 32'h00, 1'b0, 1'b0, 32'h00, 1'b0, 32'h00};
    tv[1]  = '{1'b0, 32'h00, 1'b0, 1'b1, 32'h00, 1'b0, 32'h00};
    tv[2]  = '{1'b1, 32'h00, 1'b0, 1'b1, 32'h04, 1'b0, 32'h00};
    tv[3]  = '{1'b1, 32'h04, 1'b0, 1'b1, 32'h08, 1'b1, 32'h00};
    tv[4]  = '{1'b1, 32'h08, 1'b0, 1'b1, 32'h0C, 1'b1, 32'h00};
    tv[5]  = '{1'b1, 32'h0C, 1'b0, 1'b0, 32'h00, 1'b1, 32'h00};
    tv[6]  = '{1'b0, 32'h00, 1'b1, 1'b0, 32'h00, 1'b1, 32'h00};
    tv[7]  = '{1'b0, 32'h00, 1'b0, 1'b1, 32'h10, 1'b1, 32'h04};
    tv[8]  = '{1'b1, 32'h10, 1'b0, 1'b0, 32'h00, 1'b1, 32'h04};
    tv[9]  = '{1'b0, 32'h00, 1'b1, 1'b0, 32'h00, 1'b1, 32'h04};
    tv[10] = '{1'b0, 32'h00, 1'b1, 1'b1, 32'h14, 1'b1, 32'h08};
    tv[11] = '{1'b1, 32'h14, 1'b1, 1'b1, 32'h18, 1'b1, 32'h0C};
    tv[12] = '{1'b1, 32'h18, 1'b1, 1'b1, 32'h1C, 1'b1, 32'h10};
    tv[13] = '{1'b1, 32'h1C, 1'b1, 1'b1, 32'h20, 1'b1, 32'h14};

    do_reset();
    for (int i = 0; i < 14; i++) begin
      bus.imem_rvalid = tv[i].rvalid; bus.imem_rdata = insn_of(tv[i].raddr);
      bus.id_ready = tv[i].rdy; bus.redirect_valid = 1'b0;
      @(negedge clk);
      check($sformatf("tv%0d_req", i), 32'(bus.imem_req), 32'(tv[i].req));
      if (tv[i].req) check($sformatf("tv%0d_addr", i), bus.imem_addr, tv[i].addr);
      check($sformatf("tv%0d_valid", i), 32'(bus.id_valid), 32'(tv[i].vld));
      if (tv[i].vld) begin
        check($sformatf("tv%0d_pc", i), bus.id_pc, tv[i].pc);
        check($sformatf("tv%0d_insn", i), bus.id_insn, insn_of(tv[i].pc));
      end
      @(posedge clk);
      #1;
    end

    // Redirect with two responses in flight on a 3-cycle memory.
    do_reset(); lat_lo = 3; lat_hi = 3; rdy_in = 1'b1;
    repeat (3) cycle();
    redir_in = 1'b1; rpc_in = 32'h100; cycle(); redir_in = 1'b0;
    k = 0; vseen = 1'b0;
    for (int i = 0; i < 8 && !s_req; i++) begin
      cycle(); k++; vseen |= s_vld;
    end
    check("flush_gap",   32'(k),     32'd3);
    check("flush_addr",  s_addr,     32'h100);
    check("flush_valid", 32'(vseen), 32'd0);

    // Redirect coinciding with the only outstanding response and a pop.
    do_reset(); lat_lo = 1; lat_hi = 1; rdy_in = 1'b0;
    repeat (3) cycle();
    rdy_in = 1'b1; redir_in = 1'b1; rpc_in = 32'h40; cycle();
    rdy_in = 1'b0; redir_in = 1'b0;
    cycle();
    check("rr_req",   32'(s_req), 32'd1);
    check("rr_addr",  s_addr,     32'h40);
    check("rr_valid", 32'(s_vld), 32'd0);
    cycle(); cycle();
    check("rr_valid2", 32'(s_vld), 32'd1);
    check("rr_pc",     s_pc,       32'h40);

    // Address wrap at the top of the address space.
    do_reset(); rdy_in = 1'b1;
    cycle();
    redir_in = 1'b1; rpc_in = 32'hFFFF_FFF8; cycle(); redir_in = 1'b0;
    k = 0;
    for (int i = 0; i < 3; i++) wa[i] = 32'hDEAD_BEEF;
    for (int i = 0; i < 10 && k < 3; i++) begin
      cycle();
      if (s_req) begin wa[k] = s_addr; k++; end
    end
    check("wrap_a0", wa[0], 32'hFFFF_FFF8);
    check("wrap_a1", wa[1], 32'hFFFF_FFFC);
    check("wrap_a2", wa[2], 32'h0000_0000);

    // Misaligned redirect followed by an aligned one.
    do_reset(); rdy_in = 1'b1;
    cycle();
    redir_in = 1'b1; rpc_in = 32'h102; cycle(); redir_in = 1'b0;
    nreq = 0; first = 32'hDEAD_BEEF;
    for (int i = 0; i < 5; i++) begin
      cycle();
      if (s_req) begin if (nreq == 0) first = s_addr; nreq++; end
    end
`ifdef IFETCH_ALIGN_CHECK_EN
    check("mis_fault", 32'(s_fault), 32'd1);
    check("mis_nreq",  32'(nreq),    32'd0);
`else
    check("mis_fault", 32'(s_fault), 32'd0);
    check("mis_first", first,        32'h100);
`endif
    redir_in = 1'b1; rpc_in = 32'h200; cycle(); redir_in = 1'b0;
    nreq = 0; first = 32'hDEAD_BEEF;
    for (int i = 0; i < 5; i++) begin
      cycle();
      if (s_req) begin if (nreq == 0) first = s_addr; nreq++; end
    end
    check("al_fault", 32'(s_fault), 32'd0);
    check("al_first", first,        32'h200);

    // Randomized traffic with variable in-order latency and one mid-run reset.
    do_reset(); lat_lo = 1; lat_hi = 4;
    for (int i = 0; i < 1500; i++) begin
      if (i == 750) do_reset();
      rdy_in   = ($urandom_range(9, 0) < 7);
      redir_in = ($urandom_range(24, 0) == 0);
      rpc_in   = $urandom;
      if ($urandom_range(3, 0) != 0) rpc_in[1:0] = 2'b00;
      if ($urandom_range(7, 0) == 0) rpc_in[31:4] = 28'hFFF_FFFF;
      cycle();
    end
    redir_in = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
